// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: serial line in, byte, strobes and busy out.
// master is the receiver; slave is the line driver / byte consumer.
interface uart_rx_if;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (input rxd, output data, output valid, output frame_err, output busy);
    modport slave  (output rxd, input data, input valid, input frame_err, input busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling from a free-running
// per-bit counter, single-cycle VALID / FRAME_ERR strobes.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5000,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_rx_if.master  bus
);

    localparam int unsigned CNT_W = ($clog2(CLKS_PER_BIT) > 13) ? $clog2(CLKS_PER_BIT) : 13;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic [1:0]       sync_q;
    logic [1:0]       live_q;
    logic             rxd_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
    logic             armed_q, armed_d;

    assign rxd_s = sync_q[1];

    // Synchronizer resets high so reset never looks like a start edge; live_q
    // marks when rxd_s reflects the real line rather than reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            live_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.rxd};
            live_q <= {live_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
            armed_q <= armed_d;
        end
    end

    // Next-state and registered-output logic; counter restarts on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        armed_d = armed_q | (rxd_s & live_q[1]);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (armed_q && !rxd_s) begin
                    state_d = S_START;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rxd_s ? S_IDLE : S_DATA;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a 16-cycle/bit receiver for protocol scenarios and
// a 100-cycle/bit receiver driven at skewed sender rates for sampling tolerance.
module tb_uart_rx;

    localparam int unsigned CPB  = 16;
    localparam int unsigned CPB2 = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if rif ();
    uart_rx_if rif2 ();

    uart_rx #(.CLKS_PER_BIT(CPB))  dut  (.clk(clk), .rst_n(rst_n), .bus(rif));
    uart_rx #(.CLKS_PER_BIT(CPB2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(rif2));

    int checks   = 0;
    int failures = 0;

    int         vcnt = 0, fcnt = 0, vcnt2 = 0, fcnt2 = 0, both = 0;
    logic [7:0] vq[$];
    logic [7:0] vq2[$];

    // Pulse monitor for both receivers.
    always @(negedge clk) begin
        if (rif.valid) begin
            vcnt++;
            vq.push_back(rif.data);
        end
        if (rif.frame_err) fcnt++;
        if (rif2.valid) begin
            vcnt2++;
            vq2.push_back(rif2.data);
        end
        if (rif2.frame_err) fcnt2++;
        if ((rif.valid && rif.frame_err) || (rif2.valid && rif2.frame_err)) both++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int inst, input logic v);
        if (inst == 0) rif.rxd = v;
        else           rif2.rxd = v;
    endtask

    // Drives one 8N1 frame starting at a negedge; line is left at the stop value.
    task automatic send_frame(input int inst, input logic [7:0] b, input int period, input logic stop);
        set_line(inst, 1'b0);
        hold(period);
        for (int i = 0; i < 8; i++) begin
            set_line(inst, b[i]);
            hold(period);
        end
        set_line(inst, stop);
        hold(period);
    endtask

    task automatic test_reset();
        rif.rxd  = 1'b1;
        rif2.rxd = 1'b1;
        rst_n    = 1'b0;
        hold(3);
        checks++; if (rif.data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=00", rif.data); end
        checks++; if (rif.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rif.valid); end
        checks++; if (rif.frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%0b exp=0", rif.frame_err); end
        checks++; if (rif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", rif.busy); end
        rst_n = 1'b1;
        hold(10);
        checks++; if (rif.busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset_busy got=%0b exp=0", rif.busy); end
    endtask

    task automatic test_single();
        int base_v = vcnt;
        int base_f = fcnt;
        int low_busy = 0;
        fork
            send_frame(0, 8'hA5, CPB, 1'b1);
            begin
                hold(2);
                checks++; if (rif.busy !== 1'b0) begin failures++; $display("FAIL busy_before_k2 got=%0b exp=0", rif.busy); end
                hold(1);
                checks++; if (rif.busy !== 1'b1) begin failures++; $display("FAIL busy_at_k2 got=%0b exp=1", rif.busy); end
                for (int i = 0; i < 151; i++) begin
                    hold(1);
                    if (rif.busy !== 1'b1 || rif.valid !== 1'b0) low_busy++;
                end
                checks++; if (low_busy != 0) begin failures++; $display("FAIL busy_through_frame got=%0d bad cycles exp=0", low_busy); end
                hold(1);
                checks++; if (rif.valid !== 1'b1) begin failures++; $display("FAIL valid_at_k154 got=%0b exp=1", rif.valid); end
                checks++; if (rif.data !== 8'hA5) begin failures++; $display("FAIL single_data got=%0h exp=a5", rif.data); end
                checks++; if (rif.busy !== 1'b0) begin failures++; $display("FAIL busy_with_valid got=%0b exp=0", rif.busy); end
                hold(1);
                checks++; if (rif.valid !== 1'b0) begin failures++; $display("FAIL valid_one_cycle got=%0b exp=0", rif.valid); end
            end
        join
        hold(10);
        checks++; if (vcnt - base_v != 1) begin failures++; $display("FAIL single_valid_count got=%0d exp=1", vcnt - base_v); end
        checks++; if (fcnt != base_f) begin failures++; $display("FAIL single_ferr_count got=%0d exp=0", fcnt - base_f); end
    endtask

    task automatic test_back_to_back();
        int         base_q = vq.size();
        int         base_f = fcnt;
        logic [7:0] exp_b[3] = '{8'h00, 8'hFF, 8'h5A};
        for (int i = 0; i < 3; i++) send_frame(0, exp_b[i], CPB, 1'b1);
        hold(20);
        checks++; if (vq.size() - base_q != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", vq.size() - base_q); end
        for (int i = 0; i < 3; i++) begin
            if (base_q + i < vq.size()) begin
                checks++;
                if (vq[base_q + i] !== exp_b[i]) begin
                    failures++; $display("FAIL b2b_data[%0d] got=%0h exp=%0h", i, vq[base_q + i], exp_b[i]);
                end
            end
        end
        checks++; if (fcnt != base_f) begin failures++; $display("FAIL b2b_ferr got=%0d exp=0", fcnt - base_f); end
    endtask

    task automatic test_glitch();
        int   base_v = vcnt;
        int   base_f = fcnt;
        logic saw_busy = 1'b0;
        set_line(0, 1'b0);
        hold(3);
        set_line(0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            hold(1);
            if (rif.busy === 1'b1) saw_busy = 1'b1;
        end
        checks++; if (saw_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_seen got=%0b exp=1", saw_busy); end
        checks++; if (rif.busy !== 1'b0) begin failures++; $display("FAIL glitch_back_idle got=%0b exp=0", rif.busy); end
        checks++; if (vcnt != base_v) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", vcnt - base_v); end
        checks++; if (fcnt != base_f) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", fcnt - base_f); end
        checks++; if (rif.data !== 8'h5A) begin failures++; $display("FAIL glitch_data got=%0h exp=5a", rif.data); end
    endtask

    task automatic test_frame_err();
        int base_v = vcnt;
        int base_f = fcnt;
        send_frame(0, 8'hC3, CPB, 1'b0);
        hold(100);
        set_line(0, 1'b1);
        hold(20);
        checks++; if (fcnt - base_f != 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", fcnt - base_f); end
        checks++; if (vcnt != base_v) begin failures++; $display("FAIL ferr_no_valid got=%0d exp=0", vcnt - base_v); end
        checks++; if (rif.data !== 8'h5A) begin failures++; $display("FAIL ferr_data_kept got=%0h exp=5a", rif.data); end
        send_frame(0, 8'h3C, CPB, 1'b1);
        hold(20);
        checks++; if (vcnt - base_v != 1) begin failures++; $display("FAIL after_ferr_valid got=%0d exp=1", vcnt - base_v); end
        checks++; if (rif.data !== 8'h3C) begin failures++; $display("FAIL after_ferr_data got=%0h exp=3c", rif.data); end
        checks++; if (fcnt - base_f != 1) begin failures++; $display("FAIL after_ferr_count got=%0d exp=1", fcnt - base_f); end
    endtask

    task automatic test_mid_reset();
        int base_v = vcnt;
        fork
            send_frame(0, 8'h81, CPB, 1'b1);
            begin
                hold(int'(CPB) * 5 + 8);
                rst_n = 1'b0;
                #1;
                checks++; if (rif.data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%0h exp=00", rif.data); end
                checks++; if (rif.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", rif.busy); end
                checks++; if (rif.valid !== 1'b0 || rif.frame_err !== 1'b0) begin
                    failures++; $display("FAIL midrst_strobes got=%0b%0b exp=00", rif.valid, rif.frame_err);
                end
                hold(3);
                rst_n = 1'b1;
            end
        join
        hold(20);
        checks++; if (vcnt != base_v) begin failures++; $display("FAIL midrst_aborted_valid got=%0d exp=0", vcnt - base_v); end
        send_frame(0, 8'h42, CPB, 1'b1);
        hold(20);
        checks++; if (vcnt - base_v != 1) begin failures++; $display("FAIL midrst_next_valid got=%0d exp=1", vcnt - base_v); end
        checks++; if (rif.data !== 8'h42) begin failures++; $display("FAIL midrst_next_data got=%0h exp=42", rif.data); end
    endtask

    // Sender slightly slow (1%), then 4% fast and 4% slow, back to back.
    task automatic test_loopback();
        int         base_q = vq2.size();
        int         base_f = fcnt2;
        logic [7:0] exp_b[6] = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h5A, 8'hA5};
        int         per[6]   = '{101, 101, 101, 101, 96, 104};
        for (int i = 0; i < 6; i++) send_frame(1, exp_b[i], per[i], 1'b1);
        hold(150);
        checks++; if (vq2.size() - base_q != 6) begin failures++; $display("FAIL loop_count got=%0d exp=6", vq2.size() - base_q); end
        for (int i = 0; i < 6; i++) begin
            if (base_q + i < vq2.size()) begin
                checks++;
                if (vq2[base_q + i] !== exp_b[i]) begin
                    failures++; $display("FAIL loop_data[%0d] got=%0h exp=%0h", i, vq2[base_q + i], exp_b[i]);
                end
            end
        end
        checks++; if (fcnt2 != base_f) begin failures++; $display("FAIL loop_ferr got=%0d exp=0", fcnt2 - base_f); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_mid_reset();
        test_loopback();
        checks++; if (both != 0) begin failures++; $display("FAIL valid_and_ferr_same_cycle got=%0d exp=0", both); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the design's UART transmitter.
- Takes the asynchronous serial line RXD from the board pin (or looped back from the transmitter's TXD) and outputs one received byte with a single-cycle VALID strobe.
- Bytes go to the downstream crypto/command logic.
- Bit timing comes from a free-running per-bit clock-enable counter in the CLK domain; no derived clocks.

Parameters:
- CLKS_PER_BIT, 5000, CLK cycles per serial bit (48 MHz / 9600 baud); legal range >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (floor), cycles from start-edge detection to the mid-start-bit check.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RST_N  in  1  asynchronous active-low reset; release is synchronous to CLK.
- RXD  in  1  serial input, idle high, asynchronous to CLK.
- DATA  out  8  last correctly received byte, LSB = first data bit on the line.
- VALID  out  1  one-cycle pulse; DATA is new in this cycle.
- FRAME_ERR  out  1  one-cycle pulse; stop bit sampled low.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST_N=0, any time, including mid-frame):
  - DATA=8'h00, VALID=0, FRAME_ERR=0, BUSY=0.
  - State=IDLE, counters=0.
  - Both synchronizer flops are set to 1, so reset does not fake a start edge.
- Synchronizer: two flops on RXD give rxd_s. Let edge k be the first posedge where flop 1 captures RXD=0; rxd_s=0 is first seen by the FSM at edge k+2.
- IDLE:
  - rxd_s=0 at edge k+2 -> START, bit counter cleared.
  - A line held low out of reset is not a start edge. The FSM needs rxd_s=1 for at least one cycle first (arm flag).
- START: at edge k+2+HALF_BIT, check rxd_s.
  - rxd_s=0 -> DATA state, bit index 0, baud counter restarted.
  - rxd_s=1 -> glitch: back to IDLE, no outputs.
- DATA:
  - Data bit i (i=0..7) is sampled at edge k+2+HALF_BIT+(i+1)*CLKS_PER_BIT.
  - Each sample shifts into an internal shift register, LSB first.
  - After bit 7 -> STOP.
- STOP: stop bit sampled at edge k+2+HALF_BIT+9*CLKS_PER_BIT.
  - rxd_s=1: DATA <= shift register and VALID=1 for exactly that following cycle; -> IDLE.
  - rxd_s=0: FRAME_ERR=1 for one cycle, DATA unchanged; -> WAIT_HIGH.
- WAIT_HIGH: stays until rxd_s=1 (break or line fault), then -> IDLE. Re-arm needs the line high, so a held-low line yields only one FRAME_ERR.
- Back-to-back frames: the next start bit is accepted from the first IDLE cycle after the stop sample. No extra idle time is needed beyond the sender's stop bit.
- DATA holds its value until the next VALID. There is no backpressure: the consumer must take DATA on VALID or lose it.
- VALID and FRAME_ERR are never high in the same cycle.
- Baud counter: 13 bits minimum (enough for CLKS_PER_BIT-1). It counts 0..CLKS_PER_BIT-1 and wraps. It is cleared on leaving IDLE and on every state entry.
- Rate tolerance: sampling at mid-bit accepts a sender clock error of +/-4% at 10 bits. The transmitter's 5001-cycle bit period (0.02% off) must be received error-free.
- An RXD change during a non-sample cycle has no effect.

Test Plan:
- Single byte, CLKS_PER_BIT=16:
  - Drive 0x A5 8N1 at 16 cycles/bit -> one VALID pulse with DATA=8'hA5.
  - VALID at edge k+2+8+144; FRAME_ERR never high; BUSY high from k+2 until VALID.
- Back-to-back, CLKS_PER_BIT=16: 0x00, 0xFF, 0x5A with no idle gap between frames -> three VALID pulses, DATA 00, FF, 5A in order, no FRAME_ERR.
- Glitch rejection: RXD low for 3 cycles in IDLE, then high -> BUSY pulses briefly, returns to IDLE; no VALID, no FRAME_ERR; DATA unchanged.
- Framing error: frame with stop bit=0, then line held low for 100 cycles, then high, then valid 0x3C.
  - Exactly one FRAME_ERR pulse; DATA keeps its prior value.
  - Next frame gives VALID with DATA=8'h3C.
- Reset mid-frame: assert RST_N=0 during data bit 4 of 0x81, release, send 0x42.
  - Outputs are zero immediately on assert, with no VALID for the aborted frame.
  - After release, VALID with DATA=8'h42.
- Loopback at default parameters: the transmitter at CLKS_PER_BIT=5000 sends 0x00, 0x55, 0xAA, 0xFF into RXD -> each byte received exactly, no FRAME_ERR.
